// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and types for the write-back stage
// Purpose: ResultSrc encodings, load funct3 codes and the write-back FSM state type.
// Ports: none (package).
package core_pkg;

    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;
    localparam logic [1:0] RESULT_SRC_IMM = 2'b11;

    localparam logic [2:0] LOAD_F3_LB  = 3'b000;
    localparam logic [2:0] LOAD_F3_LH  = 3'b001;
    localparam logic [2:0] LOAD_F3_LW  = 3'b010;
    localparam logic [2:0] LOAD_F3_LD  = 3'b011;
    localparam logic [2:0] LOAD_F3_LBU = 3'b100;
    localparam logic [2:0] LOAD_F3_LHU = 3'b101;
    localparam logic [2:0] LOAD_F3_LWU = 3'b110;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load lane extraction and sign/zero extension
// Purpose: picks the addressed byte/halfword/word/doubleword out of a naturally
//          aligned memory beat and extends it to XLEN; flags misaligned or illegal loads.
// Ports:
//   rd     in  XLEN      memory read data (aligned word/doubleword)
//   lane   in  log2(XLEN/8)  byte offset within the beat
//   funct3 in  3         load width/sign code
//   data   out XLEN      extended load value (0 on fault)
//   fault  out 1         misaligned or illegal load
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              rd,
    input  logic [$clog2(XLEN/8)-1:0]    lane,
    input  logic [2:0]                   funct3,
    output logic [XLEN-1:0]              data,
    output logic                         fault
);

    logic [XLEN-1:0] shifted;

    // Bring the addressed byte down to bit 0 so every width reads from the bottom.
    assign shifted = rd >> {lane, 3'b000};

    always_comb begin
        data  = '0;
        fault = 1'b0;
        case (funct3)
            LOAD_F3_LB:  data = XLEN'($signed(shifted[7:0]));
            LOAD_F3_LBU: data = XLEN'(shifted[7:0]);
            LOAD_F3_LH: begin
                if (lane[0]) fault = 1'b1;
                else         data  = XLEN'($signed(shifted[15:0]));
            end
            LOAD_F3_LHU: begin
                if (lane[0]) fault = 1'b1;
                else         data  = XLEN'(shifted[15:0]);
            end
            // On RV32 the cast is width-preserving; on RV64 it sign-extends.
            LOAD_F3_LW: begin
                if (lane[1:0] != 2'b00) fault = 1'b1;
                else                    data  = XLEN'($signed(shifted[31:0]));
            end
            LOAD_F3_LWU: begin
                if (XLEN != 64 || lane[1:0] != 2'b00) fault = 1'b1;
                else                                  data  = XLEN'(shifted[31:0]);
            end
            LOAD_F3_LD: begin
                if (XLEN != 64 || lane != '0) fault = 1'b1;
                else                          data  = rd;
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_result_stage.sv
// rtl/writeback_result_stage.sv - registered RISC-V write-back result stage
// Purpose: selects the register-file write value (ALU, load, PC+4, immediate),
//          waits for the memory response on loads and presents a registered result.
// Ports:
//   clk, reset                       clock, async active-high reset
//   in_valid / in_ready              memory-stage handshake
//   ResultSrc, ALUResult, PCPlus4,
//   ImmExt, LoadFunct3, RegWrite, Rd instruction fields from the memory stage
//   RD, mem_rvalid                   memory read response
//   flush                            kills in-flight and incoming instruction
//   wb_valid, ResultW, RdW,
//   RegWriteW, load_fault            registered write-back outputs
module writeback_result_stage
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ResultSrc,
    input  logic [XLEN-1:0]   ALUResult,
    input  logic [XLEN-1:0]   PCPlus4,
    input  logic [XLEN-1:0]   ImmExt,
    input  logic [2:0]        LoadFunct3,
    input  logic              RegWrite,
    input  logic [REG_AW-1:0] Rd,
    input  logic [XLEN-1:0]   RD,
    input  logic              mem_rvalid,
    input  logic              flush,
    output logic              wb_valid,
    output logic [XLEN-1:0]   ResultW,
    output logic [REG_AW-1:0] RdW,
    output logic              RegWriteW,
    output logic              load_fault
);

    localparam int LANE_W = $clog2(XLEN/8);

    wb_state_t         state_q, state_d;

    // Load context held while waiting on the memory response.
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              reg_write_q, reg_write_d;
    logic [REG_AW-1:0] rd_q, rd_d;

    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [REG_AW-1:0] rd_w_q, rd_w_d;
    logic              reg_write_w_q, reg_write_w_d;
    logic              load_fault_q, load_fault_d;

    logic [LANE_W-1:0] la_lane;
    logic [2:0]        la_funct3;
    logic [XLEN-1:0]   la_data;
    logic              la_fault;
    logic [REG_AW-1:0] ld_rd;
    logic              ld_reg_write;
    logic [XLEN-1:0]   nonload_value;

    assign in_ready   = (state_q == IDLE);
    assign wb_valid   = wb_valid_q;
    assign ResultW    = result_q;
    assign RdW        = rd_w_q;
    assign RegWriteW  = reg_write_w_q;
    assign load_fault = load_fault_q;

    // The aligner sees live fields for a same-cycle response and captured ones otherwise.
    always_comb begin
        la_lane      = ALUResult[LANE_W-1:0];
        la_funct3    = LoadFunct3;
        ld_rd        = Rd;
        ld_reg_write = RegWrite;
        if (state_q == WAIT_MEM) begin
            la_lane      = lane_q;
            la_funct3    = funct3_q;
            ld_rd        = rd_q;
            ld_reg_write = reg_write_q;
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rd     (RD),
        .lane   (la_lane),
        .funct3 (la_funct3),
        .data   (la_data),
        .fault  (la_fault)
    );

    always_comb begin
        nonload_value = ALUResult;
        case (ResultSrc)
            RESULT_SRC_PC4: nonload_value = PCPlus4;
            RESULT_SRC_IMM: nonload_value = ImmExt;
            default:        nonload_value = ALUResult;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        funct3_d      = funct3_q;
        reg_write_d   = reg_write_q;
        rd_d          = rd_q;
        wb_valid_d    = 1'b0;
        load_fault_d  = 1'b0;
        // Result fields hold between completions; consumers qualify with wb_valid.
        result_d      = result_q;
        rd_w_d        = rd_w_q;
        reg_write_w_d = reg_write_w_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (ResultSrc != RESULT_SRC_MEM) begin
                            wb_valid_d    = 1'b1;
                            result_d      = nonload_value;
                            rd_w_d        = Rd;
                            reg_write_w_d = RegWrite && (Rd != '0);
                        end else if (mem_rvalid) begin
                            wb_valid_d    = 1'b1;
                            result_d      = la_data;
                            rd_w_d        = ld_rd;
                            reg_write_w_d = ld_reg_write && (ld_rd != '0) && !la_fault;
                            load_fault_d  = la_fault;
                        end else begin
                            lane_d      = ALUResult[LANE_W-1:0];
                            funct3_d    = LoadFunct3;
                            reg_write_d = RegWrite;
                            rd_d        = Rd;
                            state_d     = WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        wb_valid_d    = 1'b1;
                        result_d      = la_data;
                        rd_w_d        = ld_rd;
                        reg_write_w_d = ld_reg_write && (ld_rd != '0) && !la_fault;
                        load_fault_d  = la_fault;
                        state_d       = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            lane_q        <= '0;
            funct3_q      <= '0;
            reg_write_q   <= 1'b0;
            rd_q          <= '0;
            wb_valid_q    <= 1'b0;
            result_q      <= '0;
            rd_w_q        <= '0;
            reg_write_w_q <= 1'b0;
            load_fault_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            funct3_q      <= funct3_d;
            reg_write_q   <= reg_write_d;
            rd_q          <= rd_d;
            wb_valid_q    <= wb_valid_d;
            result_q      <= result_d;
            rd_w_q        <= rd_w_d;
            reg_write_w_q <= reg_write_w_d;
            load_fault_q  <= load_fault_d;
        end
    end

endmodule

// File: tb/tb_writeback_result_stage.sv
// tb/tb_writeback_result_stage.sv - directed self-checking bench for writeback_result_stage
module tb_writeback_result_stage;

    logic        clk;
    logic        reset;

    logic        in_valid, in_ready;
    logic [1:0]  ResultSrc;
    logic [31:0] ALUResult, PCPlus4, ImmExt, RD, ResultW;
    logic [2:0]  LoadFunct3;
    logic        RegWrite, mem_rvalid, flush, wb_valid, RegWriteW, load_fault;
    logic [4:0]  Rd, RdW;

    logic        d_in_valid, d_in_ready;
    logic [1:0]  d_ResultSrc;
    logic [63:0] d_ALUResult, d_PCPlus4, d_ImmExt, d_RD, d_ResultW;
    logic [2:0]  d_LoadFunct3;
    logic        d_RegWrite, d_mem_rvalid, d_flush, d_wb_valid, d_RegWriteW, d_load_fault;
    logic [4:0]  d_Rd, d_RdW;

    int checks   = 0;
    int failures = 0;

    writeback_result_stage #(.XLEN(32), .REG_AW(5)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ResultSrc(ResultSrc), .ALUResult(ALUResult), .PCPlus4(PCPlus4), .ImmExt(ImmExt),
        .LoadFunct3(LoadFunct3), .RegWrite(RegWrite), .Rd(Rd),
        .RD(RD), .mem_rvalid(mem_rvalid), .flush(flush),
        .wb_valid(wb_valid), .ResultW(ResultW), .RdW(RdW),
        .RegWriteW(RegWriteW), .load_fault(load_fault)
    );

    writeback_result_stage #(.XLEN(64), .REG_AW(5)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .ResultSrc(d_ResultSrc), .ALUResult(d_ALUResult), .PCPlus4(d_PCPlus4), .ImmExt(d_ImmExt),
        .LoadFunct3(d_LoadFunct3), .RegWrite(d_RegWrite), .Rd(d_Rd),
        .RD(d_RD), .mem_rvalid(d_mem_rvalid), .flush(d_flush),
        .wb_valid(d_wb_valid), .ResultW(d_ResultW), .RdW(d_RdW),
        .RegWriteW(d_RegWriteW), .load_fault(d_load_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; ResultSrc = 0; ALUResult = 0; PCPlus4 = 0; ImmExt = 0;
        LoadFunct3 = 0; RegWrite = 0; Rd = 0; RD = 0; mem_rvalid = 0; flush = 0;
        d_in_valid = 0; d_ResultSrc = 0; d_ALUResult = 0; d_PCPlus4 = 0; d_ImmExt = 0;
        d_LoadFunct3 = 0; d_RegWrite = 0; d_Rd = 0; d_RD = 0; d_mem_rvalid = 0; d_flush = 0;

        // Reset state
        step; step;
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_result", 64'(ResultW), 64'd0);
        chk("rst_rdw", 64'(RdW), 64'd0);
        chk("rst_regwrite", 64'(RegWriteW), 64'd0);
        chk("rst_fault", 64'(load_fault), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;

        // ALU result
        in_valid = 1; ResultSrc = 2'b00; ALUResult = 32'h0000_1234; Rd = 5; RegWrite = 1;
        step;
        chk("alu_wb_valid", 64'(wb_valid), 64'd1);
        chk("alu_result", 64'(ResultW), 64'h1234);
        chk("alu_rdw", 64'(RdW), 64'd5);
        chk("alu_regwrite", 64'(RegWriteW), 64'd1);
        in_valid = 0;
        step;
        chk("alu_pulse_end", 64'(wb_valid), 64'd0);
        chk("alu_hold", 64'(ResultW), 64'h1234);

        // LB / LBU with same-cycle response
        in_valid = 1; ResultSrc = 2'b01; ALUResult = 32'h0000_1003; LoadFunct3 = 3'b000;
        RD = 32'h80FF_0000; mem_rvalid = 1; Rd = 7;
        step;
        chk("lb_wb_valid", 64'(wb_valid), 64'd1);
        chk("lb_result", 64'(ResultW), 64'hFFFF_FF80);
        chk("lb_rdw", 64'(RdW), 64'd7);
        chk("lb_fault", 64'(load_fault), 64'd0);
        LoadFunct3 = 3'b100;
        step;
        chk("lbu_result", 64'(ResultW), 64'h0000_0080);
        chk("lbu_wb_valid", 64'(wb_valid), 64'd1);

        // LW with response 3 cycles late; in_valid in WAIT_MEM must be ignored
        ALUResult = 32'h0000_2000; LoadFunct3 = 3'b010; Rd = 9; mem_rvalid = 0;
        step;
        chk("lw_wait1_ready", 64'(in_ready), 64'd0);
        chk("lw_wait1_wbv", 64'(wb_valid), 64'd0);
        ResultSrc = 2'b00; ALUResult = 32'h0000_2003; Rd = 3;
        step;
        chk("lw_wait2_ready", 64'(in_ready), 64'd0);
        chk("lw_wait2_wbv", 64'(wb_valid), 64'd0);
        step;
        chk("lw_wait3_ready", 64'(in_ready), 64'd0);
        chk("lw_wait3_wbv", 64'(wb_valid), 64'd0);
        in_valid = 0; mem_rvalid = 1; RD = 32'hDEAD_BEEF;
        step;
        chk("lw_wb_valid", 64'(wb_valid), 64'd1);
        chk("lw_result", 64'(ResultW), 64'hDEAD_BEEF);
        chk("lw_rdw", 64'(RdW), 64'd9);
        chk("lw_regwrite", 64'(RegWriteW), 64'd1);
        chk("lw_fault", 64'(load_fault), 64'd0);
        chk("lw_ready_after", 64'(in_ready), 64'd1);
        mem_rvalid = 0;
        step;
        chk("lw_pulse_end", 64'(wb_valid), 64'd0);

        // Misaligned LH
        in_valid = 1; ResultSrc = 2'b01; ALUResult = 32'h0000_1001; LoadFunct3 = 3'b001;
        RD = 32'h1234_5678; mem_rvalid = 1; Rd = 4; RegWrite = 1;
        step;
        chk("lh_mis_wbv", 64'(wb_valid), 64'd1);
        chk("lh_mis_fault", 64'(load_fault), 64'd1);
        chk("lh_mis_regwrite", 64'(RegWriteW), 64'd0);
        chk("lh_mis_result", 64'(ResultW), 64'd0);

        // LD is illegal on RV32
        ALUResult = 32'h0000_1000; LoadFunct3 = 3'b011;
        step;
        chk("ld32_fault", 64'(load_fault), 64'd1);
        chk("ld32_result", 64'(ResultW), 64'd0);

        // Aligned LH on upper half
        ALUResult = 32'h0000_1002; LoadFunct3 = 3'b001; RD = 32'h8001_0000;
        step;
        chk("lh_result", 64'(ResultW), 64'hFFFF_8001);
        chk("lh_fault", 64'(load_fault), 64'd0);

        // Flush during WAIT_MEM, then a stray response
        mem_rvalid = 0; ALUResult = 32'h0000_3000; LoadFunct3 = 3'b010; Rd = 6;
        step;
        chk("fl_waiting", 64'(in_ready), 64'd0);
        in_valid = 0; flush = 1;
        step;
        chk("fl_ready", 64'(in_ready), 64'd1);
        chk("fl_no_wbv", 64'(wb_valid), 64'd0);
        flush = 0; mem_rvalid = 1; RD = 32'h5555_AAAA;
        step;
        chk("fl_stray_wbv", 64'(wb_valid), 64'd0);
        chk("fl_stray_ready", 64'(in_ready), 64'd1);
        mem_rvalid = 0;

        // Flush drops a same-cycle non-load
        in_valid = 1; flush = 1; ResultSrc = 2'b00; ALUResult = 32'h0000_0777; Rd = 2;
        step;
        chk("fl_drop_wbv", 64'(wb_valid), 64'd0);
        flush = 0;

        // Rd=0 suppresses the write but not the value
        ResultSrc = 2'b10; PCPlus4 = 32'h0000_0104; Rd = 0; RegWrite = 1;
        step;
        chk("x0_wbv", 64'(wb_valid), 64'd1);
        chk("x0_result", 64'(ResultW), 64'h104);
        chk("x0_regwrite", 64'(RegWriteW), 64'd0);

        // Immediate
        ResultSrc = 2'b11; ImmExt = 32'hABCD_E000; Rd = 1;
        step;
        chk("imm_result", 64'(ResultW), 64'hABCD_E000);
        chk("imm_rdw", 64'(RdW), 64'd1);
        chk("imm_regwrite", 64'(RegWriteW), 64'd1);

        // Eight back-to-back non-loads
        ResultSrc = 2'b00;
        for (int i = 0; i < 8; i++) begin
            ALUResult = 32'(100 + i); Rd = 5'(i + 1);
            step;
            chk("b2b_wbv", 64'(wb_valid), 64'd1);
            chk("b2b_result", 64'(ResultW), 64'(100 + i));
            chk("b2b_rdw", 64'(RdW), 64'(i + 1));
        end

        // Asynchronous reset while waiting on a load
        ResultSrc = 2'b01; ALUResult = 32'h0000_4000; LoadFunct3 = 3'b010; Rd = 8; mem_rvalid = 0;
        step;
        in_valid = 0;
        chk("rw_waiting", 64'(in_ready), 64'd0);
        chk("rw_held_result", 64'(ResultW), 64'd107);
        #2 reset = 1'b1;
        #1;
        chk("rw_ready", 64'(in_ready), 64'd1);
        chk("rw_result", 64'(ResultW), 64'd0);
        chk("rw_rdw", 64'(RdW), 64'd0);
        chk("rw_regwrite", 64'(RegWriteW), 64'd0);
        chk("rw_wbv", 64'(wb_valid), 64'd0);
        step;
        reset = 1'b0;
        mem_rvalid = 1; RD = 32'h1111_2222;
        step;
        chk("rw_lost_wbv", 64'(wb_valid), 64'd0);
        mem_rvalid = 0;

        // RV64 loads
        d_in_valid = 1; d_ResultSrc = 2'b01; d_ALUResult = 64'h0000_0000_0000_8000;
        d_LoadFunct3 = 3'b011; d_RD = 64'h0123_4567_89AB_CDEF; d_mem_rvalid = 1;
        d_Rd = 10; d_RegWrite = 1;
        step;
        chk("ld64_wbv", 64'(d_wb_valid), 64'd1);
        chk("ld64_result", d_ResultW, 64'h0123_4567_89AB_CDEF);
        chk("ld64_fault", 64'(d_load_fault), 64'd0);
        d_ALUResult = 64'h0000_0000_0000_8004; d_LoadFunct3 = 3'b110;
        d_RD = 64'hFFFF_FFFF_0000_0000;
        step;
        chk("lwu64_result", d_ResultW, 64'h0000_0000_FFFF_FFFF);
        d_LoadFunct3 = 3'b010;
        step;
        chk("lw64_sext", d_ResultW, 64'hFFFF_FFFF_FFFF_FFFF);
        d_LoadFunct3 = 3'b011;
        step;
        chk("ld64_mis_fault", 64'(d_load_fault), 64'd1);
        chk("ld64_mis_regwrite", 64'(d_RegWriteW), 64'd0);
        chk("ld64_mis_result", d_ResultW, 64'd0);
        d_in_valid = 0; d_mem_rvalid = 0;
        step;
        chk("d64_pulse_end", 64'(d_wb_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_result_stage.md
# writeback_result_stage

Parametrised successor to the single-cycle ResultSrc multiplexer: the registered write-back stage of the RISC-V core. It selects the register-file write value from ALU result, memory read data, PC+4 or immediate. Load data is aligned and sign/zero-extended per funct3, and the stage waits on a memory-response handshake. It sits between the memory stage and the register file.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- REG_AW, 5, register-address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  memory-stage instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- ResultSrc  in  2  00 ALUResult, 01 load data, 10 PCPlus4, 11 ImmExt
- ALUResult  in  XLEN  ALU result; also the load address
- PCPlus4  in  XLEN  PC+4
- ImmExt  in  XLEN  extended immediate (LUI)
- LoadFunct3  in  3  load width/sign code
- RegWrite  in  1  instruction writes rd
- Rd  in  REG_AW  destination register
- RD  in  XLEN  memory read data, naturally aligned word/doubleword
- mem_rvalid  in  1  RD valid this cycle
- flush  in  1  kill in-flight and incoming instruction
- wb_valid  out  1  one-cycle pulse: ResultW/RdW/RegWriteW valid
- ResultW  out  XLEN  write-back value
- RdW  out  REG_AW  destination register
- RegWriteW  out  1  register-file write enable
- load_fault  out  1  pulses with wb_valid on misaligned or illegal load

## Operation
- States: IDLE, WAIT_MEM. in_ready = (state==IDLE).
- IDLE, in_valid, !flush, ResultSrc≠01: complete immediately.
- IDLE, accepted load, mem_rvalid=1: complete with the same-cycle RD.
- IDLE, accepted load, mem_rvalid=0: capture ALUResult, LoadFunct3, RegWrite and Rd. Go to WAIT_MEM.
- WAIT_MEM, mem_rvalid=1: complete with RD, go to IDLE. in_valid is ignored in WAIT_MEM.
- flush (any state): go to IDLE, no completion. A same-cycle in_valid is dropped. Same-cycle mem_rvalid is discarded.
- mem_rvalid in IDLE with no accepted load: ignored.
- Load extraction: lane = ALUResult[log2(XLEN/8)-1:0].
  - 000 LB and 100 LBU: byte at lane; sign- or zero-extend.
  - 001 LH and 101 LHU: halfword; requires lane[0]=0.
  - 010 LW: word; requires lane[1:0]=0; sign-extend when XLEN=64.
  - 110 LWU and 011 LD: legal only when XLEN=64. LD requires lane=0.
- Misaligned or illegal load: ResultW=0, RegWriteW=0, load_fault=1.
- Rd==0 forces RegWriteW=0. ResultW still carries the selected value.

## Timing
- Reset values: state IDLE, wb_valid 0, ResultW 0, RdW 0, RegWriteW 0, load_fault 0.
- All outputs are registered.
- Completion in cycle N makes wb_valid=1 in cycle N+1, for exactly one cycle.
- Non-load latency is 1 cycle. A load takes 1 cycle after the mem_rvalid beat.
- Throughput is one instruction per cycle with no loads stalled.
- ResultW, RdW and RegWriteW hold their last values while wb_valid=0. Consumers qualify them with wb_valid.
- Reset asserted mid-WAIT_MEM: the state returns to IDLE asynchronously and the captured load is lost.

## Structure
- Shared package core_pkg holds:
  - RESULT_SRC_ALU/MEM/PC4/IMM constants;
  - LOAD_F3_LB..LOAD_F3_LD constants;
  - wb_state_t enum.
- One sub-module, load_align: combinational, parametrised by XLEN. Inputs are RD, lane and funct3; outputs are the extended data and a fault flag. It is verified standalone.

## Test plan
- ResultSrc=00, ALUResult=0x0000_1234, Rd=5, RegWrite=1. Expect wb_valid the next cycle with ResultW=0x1234, RdW=5, RegWriteW=1.
- LB with ALUResult=0x...03, RD=0x80FF_0000, mem_rvalid the same cycle. Expect ResultW=0xFFFF_FF80.
- LBU with the same stimulus. Expect ResultW=0x0000_0080.
- LW with mem_rvalid delayed 3 cycles:
  - in_ready=0 for 3 cycles;
  - wb_valid one cycle after mem_rvalid, ResultW=RD.
- LH at address 0x...01. Expect load_fault=1, RegWriteW=0, ResultW=0.
- XLEN=64: LD at lane 0 returns the full RD. LWU of 0xFFFF_FFFF returns 0x0000_0000_FFFF_FFFF.
- Flush during WAIT_MEM, then mem_rvalid: no wb_valid, in_ready=1 the next cycle.
- Reset mid-WAIT_MEM: all outputs 0.
- Rd=0 with RegWrite=1, ResultSrc=10, PCPlus4=0x104. Expect ResultW=0x104, RegWriteW=0.
- ResultSrc=11, ImmExt=0xABCD_E000. Expect ResultW=0xABCD_E000.
- Back-to-back non-loads for 8 cycles: 8 consecutive wb_valid pulses.
